// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter and transaction sequencer between N_REQ
// per-core L1 miss ports and the single-ported shared L2 array.
// One core is granted at a time; its request is forwarded to the array.
// On a write, every other core's L1 is told to invalidate the written
// address, and completion waits until all of them have acknowledged.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   en/w/addr/d_in    per-core request valid, write flag, address, write data
//   d_out/ready       per-core read data and one-cycle completion pulse
//   invalidate        per-core invalidation request, address on inv_addr
//   invalidated       per-core invalidation acknowledge (pulse or level)
//   mem_*             single array port (request/flag/address/data, response)
//   busy              high whenever the sequencer is not IDLE
//   grant_id          current or last owner index
module l2_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              en,
  input  logic [N_REQ-1:0]              w,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  d_in,
  output logic [N_REQ-1:0][DATA_W-1:0]  d_out,
  output logic [N_REQ-1:0]              ready,
  output logic [N_REQ-1:0]              invalidate,
  output logic [ADDR_W-1:0]             inv_addr,
  input  logic [N_REQ-1:0]              invalidated,
  output logic                          mem_en,
  output logic                          mem_w,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_in,
  input  logic [DATA_W-1:0]             mem_out,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    INVAL = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                        state_r, state_s;
  logic [IDX_W-1:0]              rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]              owner_r, owner_s;
  logic                          wr_r, wr_s;
  logic [ADDR_W-1:0]             addr_r, addr_s;
  logic [DATA_W-1:0]             wdata_r, wdata_s;
  logic [DATA_W-1:0]             rdata_r, rdata_s;
  logic [N_REQ-1:0]              ack_mask_r, ack_mask_s;
  logic                          mem_en_r, mem_en_s;
  logic [N_REQ-1:0]              ready_r, ready_s;
  logic [N_REQ-1:0]              invalidate_r, invalidate_s;
  logic [N_REQ-1:0][DATA_W-1:0]  d_out_r, d_out_s;
  logic [ADDR_W-1:0]             inv_addr_r, inv_addr_s;

  logic                          found_s;
  logic [IDX_W-1:0]              pick_s;
  logic                          pick_w_s;
  logic [ADDR_W-1:0]             pick_addr_s;
  logic [DATA_W-1:0]             pick_data_s;
  logic [N_REQ-1:0]              owner_oh_s;
  logic [N_REQ-1:0]              acks_s;

  // Round-robin pick: first pass covers indices at or above rr_ptr, the
  // second pass wraps around to the low indices.
  always_comb begin
    found_s     = 1'b0;
    pick_s      = '0;
    pick_w_s    = 1'b0;
    pick_addr_s = '0;
    pick_data_s = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found_s && en[j] && (IDX_W'(j) >= rr_ptr_r)) begin
        found_s     = 1'b1;
        pick_s      = IDX_W'(j);
        pick_w_s    = w[j];
        pick_addr_s = addr[j];
        pick_data_s = d_in[j];
      end else begin
        found_s     = found_s;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found_s && en[j]) begin
        found_s     = 1'b1;
        pick_s      = IDX_W'(j);
        pick_w_s    = w[j];
        pick_addr_s = addr[j];
        pick_data_s = d_in[j];
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Owner one-hot and the accumulated acknowledge mask for this cycle.
  always_comb begin
    owner_oh_s = '0;
    for (int j = 0; j < N_REQ; j++) begin
      owner_oh_s[j] = (IDX_W'(j) == owner_r);
    end
    acks_s = ack_mask_r | invalidated;
  end

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_s      = state_r;
    rr_ptr_s     = rr_ptr_r;
    owner_s      = owner_r;
    wr_s         = wr_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    rdata_s      = rdata_r;
    ack_mask_s   = ack_mask_r;
    mem_en_s     = mem_en_r;
    ready_s      = '0;
    invalidate_s = invalidate_r;
    d_out_s      = d_out_r;
    inv_addr_s   = inv_addr_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          owner_s  = pick_s;
          rr_ptr_s = (pick_s == IDX_W'(N_REQ - 1)) ? '0 : pick_s + IDX_W'(1);
          wr_s     = pick_w_s;
          addr_s   = pick_addr_s;
          wdata_s  = pick_data_s;
          mem_en_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s  = IDLE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          rdata_s  = mem_out;
          mem_en_s = 1'b0;
          if (wr_r && (N_REQ > 1)) begin
            // Owner starts out acknowledged, so it is never invalidated.
            ack_mask_s   = owner_oh_s;
            invalidate_s = ~owner_oh_s;
            inv_addr_s   = addr_r;
            state_s      = INVAL;
          end else begin
            ready_s = owner_oh_s;
            for (int j = 0; j < N_REQ; j++) begin
              if (owner_oh_s[j]) begin
                d_out_s[j] = mem_out;
              end else begin
                d_out_s[j] = d_out_r[j];
              end
            end
            state_s = RESP;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      INVAL: begin
        ack_mask_s   = acks_s;
        invalidate_s = ~acks_s;
        if (&acks_s) begin
          ready_s = owner_oh_s;
          for (int j = 0; j < N_REQ; j++) begin
            if (owner_oh_s[j]) begin
              d_out_s[j] = rdata_r;
            end else begin
              d_out_s[j] = d_out_r[j];
            end
          end
          state_s = RESP;
        end else begin
          state_s = INVAL;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
      wr_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      rdata_r      <= '0;
      ack_mask_r   <= '0;
      mem_en_r     <= 1'b0;
      ready_r      <= '0;
      invalidate_r <= '0;
      d_out_r      <= '0;
      inv_addr_r   <= '0;
    end else begin
      state_r      <= state_s;
      rr_ptr_r     <= rr_ptr_s;
      owner_r      <= owner_s;
      wr_r         <= wr_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      rdata_r      <= rdata_s;
      ack_mask_r   <= ack_mask_s;
      mem_en_r     <= mem_en_s;
      ready_r      <= ready_s;
      invalidate_r <= invalidate_s;
      d_out_r      <= d_out_s;
      inv_addr_r   <= inv_addr_s;
    end
  end

  assign mem_en     = mem_en_r;
  assign mem_w      = wr_r;
  assign mem_addr   = addr_r;
  assign mem_in     = wdata_r;
  assign ready      = ready_r;
  assign d_out      = d_out_r;
  assign invalidate = invalidate_r;
  assign inv_addr   = inv_addr_r;
  assign grant_id   = owner_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

  typedef struct {
    logic        w;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;   // mem_ready this many cycles after first ISSUE cycle; <0 = never
  } mem_t;

  typedef struct {
    int          core;
    logic [15:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // four-core instance
  logic [3:0]        en = '0, w = '0, rearm = '0, ready, invalidate, invalidated = '0;
  logic [3:0][15:0]  addr = '0, d_in = '0, d_out;
  logic [15:0]       inv_addr, mem_addr, mem_in, mem_out = '0;
  logic              mem_en, mem_w, mem_ready = 1'b0, busy;
  logic [1:0]        grant_id;

  // single-core instance
  logic [0:0]        en1 = '0, w1 = '0, ready1, invalidate1, invalidated1 = '0;
  logic [0:0][15:0]  addr1 = '0, d_in1 = '0, d_out1;
  logic [15:0]       inv_addr1, mem_addr1, mem_in1, mem_out1 = '0;
  logic              mem_en1, mem_w1, mem_ready1 = 1'b0, busy1;
  logic [0:0]        grant_id1;

  int checks = 0;
  int errors = 0;
  mem_t  mem_exp[$];
  resp_t resp_exp[$];

  l2_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .w(w), .addr(addr), .d_in(d_in),
    .d_out(d_out), .ready(ready), .invalidate(invalidate), .inv_addr(inv_addr),
    .invalidated(invalidated), .mem_en(mem_en), .mem_w(mem_w), .mem_addr(mem_addr),
    .mem_in(mem_in), .mem_out(mem_out), .mem_ready(mem_ready), .busy(busy),
    .grant_id(grant_id)
  );

  l2_arbiter #(.N_REQ(1), .ADDR_W(16), .DATA_W(16)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .w(w1), .addr(addr1), .d_in(d_in1),
    .d_out(d_out1), .ready(ready1), .invalidate(invalidate1), .inv_addr(inv_addr1),
    .invalidated(invalidated1), .mem_en(mem_en1), .mem_w(mem_w1), .mem_addr(mem_addr1),
    .mem_in(mem_in1), .mem_out(mem_out1), .mem_ready(mem_ready1), .busy(busy1),
    .grant_id(grant_id1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; a requester drops en after its ready
  // unless it was armed to re-request.
  task automatic step();
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      if (ready[j]) begin
        if (rearm[j]) rearm[j] = 1'b0;
        else en[j] = 1'b0;
      end
    end
  endtask

  task automatic push_mem(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] rd, input int lat);
    mem_t m;
    m.w = wr; m.addr = a; m.wdata = wd; m.rdata = rd; m.lat = lat;
    mem_exp.push_back(m);
  endtask

  task automatic push_resp(input int core, input logic [15:0] data);
    resp_t r;
    r.core = core; r.data = data;
    resp_exp.push_back(r);
  endtask

  task automatic req(input int core, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    en[core] = 1'b1; w[core] = wr; addr[core] = a; d_in[core] = wd;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((resp_exp.size() != 0 || mem_exp.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_idle_timeout"}, (n >= 200) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    fork
      begin : stimulus
        step(); step();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_ready", ready, 0);
        chk("rst_invalidate", invalidate, 0);
        chk("rst_inv_addr", inv_addr, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_d_out", d_out[31:0], 0);
        rst = 1'b0;
        step();

        // single read, core 2, mem_ready three cycles after request
        req(2, 1'b0, 16'h0010, 16'h0000);
        push_mem(1'b0, 16'h0010, 16'h0000, 16'hABCD, 2);
        push_resp(2, 16'hABCD);
        step();
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant_id, 2);
        step(); step(); step(); step();
        chk("t1_busy_low", busy, 0);
        wait_idle("t1");

        // contention from rr_ptr = 0
        rst = 1'b1; step(); rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (j != 2) begin
            req(j, 1'b0, 16'h0100 + 16'(j), 16'h0000);
            push_mem(1'b0, 16'h0100 + 16'(j), 16'h0000, 16'h1000 + 16'(j), 0);
            push_resp(j, 16'h1000 + 16'(j));
          end
        end
        wait_idle("t2a");
        for (int j = 0; j < 4; j++) begin
          req(j, 1'b0, 16'h0200 + 16'(j), 16'h0000);
          push_mem(1'b0, 16'h0200 + 16'(j), 16'h0000, 16'h2000 + 16'(j), 0);
          push_resp(j, 16'h2000 + 16'(j));
        end
        wait_idle("t2b");

        // write with invalidation, staggered acks
        req(1, 1'b1, 16'h0020, 16'h5A5A);
        push_mem(1'b1, 16'h0020, 16'h5A5A, 16'h1111, 0);
        push_resp(1, 16'h1111);
        step(); step();
        chk("t3_inv_start", invalidate, 4'b1101);
        chk("t3_inv_addr", inv_addr, 16'h0020);
        invalidated = 4'b1000;
        step();
        chk("t3_inv_after3", invalidate, 4'b0101);
        invalidated = 4'b0000;
        step();
        chk("t3_inv_hold1", invalidate, 4'b0101);
        step();
        chk("t3_inv_hold2", invalidate, 4'b0101);
        invalidated = 4'b0101;
        step();
        chk("t3_inv_done", invalidate, 4'b0000);
        chk("t3_ready", ready, 4'b0010);
        invalidated = 4'b0000;
        wait_idle("t3");

        // back-to-back single requester, then drop
        rearm[0] = 1'b1;
        req(0, 1'b0, 16'h0030, 16'h0000);
        push_mem(1'b0, 16'h0030, 16'h0000, 16'h3001, 0);
        push_mem(1'b0, 16'h0030, 16'h0000, 16'h3002, 0);
        push_resp(0, 16'h3001);
        push_resp(0, 16'h3002);
        step(); step();
        chk("t4_en_kept", en[0], 1);
        step();
        chk("t4_idle_gap", busy, 0);
        step();
        chk("t4_regrant_busy", busy, 1);
        chk("t4_regrant_id", grant_id, 0);
        wait_idle("t4");
        step();
        chk("t4_drop_busy", busy, 0);
        chk("t4_drop_mem_en", mem_en, 0);

        // reset mid-INVAL
        req(3, 1'b1, 16'h0040, 16'h3333);
        push_mem(1'b1, 16'h0040, 16'h3333, 16'h0000, 0);
        step(); step();
        chk("t5_inval_pre", invalidate, 4'b0111);
        rst = 1'b1; en[3] = 1'b0;
        step();
        rst = 1'b0;
        chk("t5_inval_inv", invalidate, 0);
        chk("t5_inval_mem_en", mem_en, 0);
        chk("t5_inval_busy", busy, 0);
        chk("t5_inval_inv_addr", inv_addr, 0);
        // reset mid-ISSUE (core 2 leaves rr_ptr at 3)
        req(2, 1'b0, 16'h0050, 16'h0000);
        push_mem(1'b0, 16'h0050, 16'h0000, 16'h0000, -1);
        step();
        chk("t5_issue_mem_en", mem_en, 1);
        rst = 1'b1; en[2] = 1'b0;
        step();
        rst = 1'b0;
        chk("t5_issue_mem_en_low", mem_en, 0);
        chk("t5_issue_grant", grant_id, 0);
        chk("t5_issue_ready", ready, 0);
        step();
        // rr_ptr back at 0: core 2 beats core 3
        req(2, 1'b0, 16'h0060, 16'h0000);
        req(3, 1'b0, 16'h0070, 16'h0000);
        push_mem(1'b0, 16'h0060, 16'h0000, 16'h6002, 0);
        push_mem(1'b0, 16'h0070, 16'h0000, 16'h6003, 0);
        push_resp(2, 16'h6002);
        push_resp(3, 16'h6003);
        wait_idle("t5_post");

        // single-core build: write goes straight to RESP
        en1 = 1'b1; w1 = 1'b1; addr1[0] = 16'h0080; d_in1[0] = 16'h4444;
        step();
        chk("t6_mem_en", mem_en1, 1);
        chk("t6_mem_w", mem_w1, 1);
        chk("t6_mem_in", mem_in1, 16'h4444);
        chk("t6_inv_issue", invalidate1, 0);
        mem_ready1 = 1'b1; mem_out1 = 16'h7777;
        step();
        chk("t6_ready", ready1, 1);
        chk("t6_d_out", d_out1[0], 16'h7777);
        chk("t6_inv_resp", invalidate1, 0);
        mem_ready1 = 1'b0; en1 = 1'b0;
        step();
        chk("t6_ready_low", ready1, 0);
        chk("t6_busy_low", busy1, 0);

        chk("mem_queue_empty", mem_exp.size(), 0);
        chk("resp_queue_empty", resp_exp.size(), 0);
      end
      begin : monitor
        resp_t r;
        forever begin
          @(negedge clk);
          if (ready !== 4'b0000) begin
            if ($countones(ready) != 1) begin
              chk("ready_onehot", ready, 0);
            end else if (resp_exp.size() == 0) begin
              chk("ready_unexpected", ready, 0);
            end else begin
              r = resp_exp.pop_front();
              for (int j = 0; j < 4; j++) begin
                if (ready[j]) begin
                  chk("resp_core", j, r.core);
                  chk("resp_data", d_out[j], r.data);
                end
              end
            end
          end
        end
      end
      begin : responder
        mem_t m;
        forever begin
          @(negedge clk);
          if (mem_en === 1'b1) begin
            if (mem_exp.size() == 0) begin
              chk("mem_unexpected", 1, 0);
              for (int k = 0; k < 50 && mem_en; k++) @(negedge clk);
            end else begin
              m = mem_exp.pop_front();
              chk("mem_w", mem_w, m.w);
              chk("mem_addr", mem_addr, m.addr);
              if (m.w) chk("mem_in", mem_in, m.wdata);
              if (m.lat < 0) begin
                for (int k = 0; k < 50 && mem_en; k++) @(negedge clk);
              end else begin
                for (int k = 0; k < m.lat; k++) begin
                  @(negedge clk);
                  chk("mem_hold", {mem_en, mem_addr}, {1'b1, m.addr});
                end
                mem_ready = 1'b1; mem_out = m.rdata;
                @(negedge clk);
                mem_ready = 1'b0;
                chk("mem_en_drop", mem_en, 0);
              end
            end
          end
        end
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
